// File: rtl/csr_uart_rx_fifo.sv
// CSR-mapped UART receiver with a byte FIFO.
// Data CSR at BASE_ADDR: reading it pops one byte (bit 31 set when empty).
// Status CSR at BASE_ADDR+1: sticky overrun/frame_error (W1C), full, empty, count.
// Handshake: there is no stall path. valid answers purely from addr in the same
// cycle, and a pop happens only on a cycle where read=1 hits the data CSR with
// a non-empty FIFO. The receiver pushes with push_req for exactly one cycle,
// and a push is accepted only when a slot is free at that edge.
module csr_uart_rx_fifo #(
  parameter logic [11:0] BASE_ADDR  = 12'hBC4,
  parameter int          CLOCK_RATE = 200_000_000,
  parameter int          BAUD_RATE  = 115200,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx,
  input  logic        AVOID_WARNING
);

  localparam int BIT   = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CNT_W = $clog2(BIT) + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0]    HALF_LOAD = CNT_W'(BIT / 2 - 1);
  localparam logic [CNT_W-1:0]    FULL_LOAD = CNT_W'(BIT - 1);
  localparam logic [11:0]         STAT_ADDR = BASE_ADDR + 12'd1;
  localparam logic [DEPTH_LOG2:0] DEPTH_P   = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 sync1_q, sync2_q;
  logic                 push_req, frame_set;

  logic [7:0]           mem [DEPTH];
  logic [DEPTH_LOG2:0]  wptr_q, rptr_q, count;
  logic                 full, empty, pop, push, ovr_set;
  logic                 overrun_q, frame_q;
  logic                 data_hit, stat_hit;
  logic [1:0]           clr_bits;
  logic [7:0]           head, count8;
  logic                 unused_ok;

  assign unused_ok = ^{AVOID_WARNING, wdata[31:2]};

  // Two-flop synchroniser for the asynchronous line, idling high.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Receiver next state: half-bit wait to centre on the start bit, then one
  // full bit period per data bit and for the stop bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!sync2_q) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (sync2_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
            cnt_d   = FULL_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = sync2_q;
          cnt_d          = FULL_LOAD;
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (sync2_q) push_req  = 1'b1;
          else         frame_set = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_hit = (addr == BASE_ADDR);
  assign stat_hit = (addr == STAT_ADDR);
  assign valid    = data_hit | stat_hit;

  assign count   = wptr_q - rptr_q;
  assign full    = (count == DEPTH_P);
  assign empty   = (wptr_q == rptr_q);
  assign pop     = read & data_hit & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push    = push_req & (~full | pop);
  assign ovr_set = push_req & ~push;
  assign clr_bits = (stat_hit && (modify == 3'd1 || modify == 3'd3)) ? wdata[1:0] : 2'b00;
  assign head    = mem[rptr_q[DEPTH_LOG2-1:0]];
  assign count8  = 8'(count);

  // FIFO pointers and sticky flags; a set in the same cycle beats a clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      overrun_q <= ovr_set   | (overrun_q & ~clr_bits[0]);
      frame_q   <= frame_set | (frame_q   & ~clr_bits[1]);
    end
  end

  // FIFO storage; contents need no reset since the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[DEPTH_LOG2-1:0]] <= shift_q;
  end

  // Read mux: zero unless one of our two addresses is selected.
  always_comb begin
    rdata = 32'h0;
    if (data_hit) begin
      rdata = empty ? 32'h8000_0000 : {24'h0, head};
    end else if (stat_hit) begin
      rdata = {16'h0, count8, 4'h0, empty, full, frame_q, overrun_q};
    end
  end

endmodule

// File: tb/tb_csr_uart_rx_fifo.sv
// Directed bench for csr_uart_rx_fifo: 16 clocks per bit, 4-byte FIFO.
module tb_csr_uart_rx_fifo;

  localparam logic [11:0] BASE = 12'hBC4;
  localparam logic [11:0] STAT = 12'hBC5;

  logic        clk = 1'b0;
  logic        rstn;
  logic        read;
  logic [2:0]  modify;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        valid;
  logic        rx;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] pop_seen;

  csr_uart_rx_fifo #(
    .BASE_ADDR (BASE),
    .CLOCK_RATE(16),
    .BAUD_RATE (1),
    .DEPTH_LOG2(2)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .read         (read),
    .modify       (modify),
    .wdata        (wdata),
    .addr         (addr),
    .rdata        (rdata),
    .valid        (valid),
    .rx           (rx),
    .AVOID_WARNING(1'b0)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic v);
    @(posedge clk); #1;
    addr = a; read = 1'b1;
    #3;
    d = rdata; v = valid;
    @(posedge clk); #1;
    read = 1'b0; addr = 12'h000;
  endtask

  task automatic peek(input logic [11:0] a, output logic [31:0] d, output logic v);
    @(posedge clk); #1;
    addr = a;
    #3;
    d = rdata; v = valid;
    @(posedge clk); #1;
    addr = 12'h000;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [2:0] m, input logic [31:0] wd);
    @(posedge clk); #1;
    addr = a; modify = m; wdata = wd;
    @(posedge clk); #1;
    addr = 12'h000; modify = 3'd0; wdata = 32'h0;
  endtask

  // Sends start, 8 data bits LSB first, and a stop bit of value stop_v.
  // pop_edge > 0 holds a data-CSR read across that edge (counted from frame start).
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int pop_edge);
    logic [9:0] bits;
    int e;
    bits = {stop_v, b, 1'b0};
    e = 0;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int j = 0; j < 16; j++) begin
        @(posedge clk); #1;
        e++;
        if (pop_edge > 0 && e == pop_edge - 1) begin
          addr = BASE; read = 1'b1;
          #3;
          pop_seen = rdata;
        end
        if (pop_edge > 0 && e == pop_edge) begin
          read = 1'b0; addr = 12'h000;
        end
      end
    end
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [31:0] d;
    logic v;
    rstn = 1'b0; read = 1'b0; modify = 3'd0; wdata = 32'h0; addr = 12'h000; rx = 1'b1;
    idle(3);
    #3;
    n_vec++; if (valid !== 1'b0 || rdata !== 32'h0) begin n_bad++;
      $display("FAIL reset_idle_bus got valid=%b rdata=%h want valid=0 rdata=0", valid, rdata); end
    idle(1);
    rstn = 1'b1;
    idle(2);
    peek(BASE, d, v);
    n_vec++; if (v !== 1'b1) begin n_bad++; $display("FAIL reset_valid_data got %b want 1", v); end
    n_vec++; if (d !== 32'h8000_0000) begin n_bad++; $display("FAIL reset_data got %h want 80000000", d); end
    peek(STAT, d, v);
    n_vec++; if (v !== 1'b1) begin n_bad++; $display("FAIL reset_valid_stat got %b want 1", v); end
    n_vec++; if (d !== 32'h0000_0008) begin n_bad++; $display("FAIL reset_status got %h want 00000008", d); end
    peek(12'hBC3, d, v);
    n_vec++; if (v !== 1'b0 || d !== 32'h0) begin n_bad++;
      $display("FAIL reset_miss_below got valid=%b rdata=%h want 0/0", v, d); end
    peek(12'hBC6, d, v);
    n_vec++; if (v !== 1'b0 || d !== 32'h0) begin n_bad++;
      $display("FAIL reset_miss_above got valid=%b rdata=%h want 0/0", v, d); end
  endtask

  task automatic test_single;
    logic [31:0] d;
    logic v;
    send_frame(8'hA5, 1'b1, 0);
    idle(4);
    peek(STAT, d, v);
    n_vec++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL single_status_before got %h want 00000100", d); end
    do_read(BASE, d, v);
    n_vec++; if (d !== 32'h0000_00A5) begin n_bad++; $display("FAIL single_data got %h want 000000a5", d); end
    peek(STAT, d, v);
    n_vec++; if (d !== 32'h0000_0008) begin n_bad++; $display("FAIL single_status_after got %h want 00000008", d); end
    do_read(BASE, d, v);
    n_vec++; if (d !== 32'h8000_0000) begin n_bad++; $display("FAIL single_empty_read got %h want 80000000", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic v;
    logic [31:0] exp_st [3];
    exp_st = '{32'h0000_0200, 32'h0000_0100, 32'h0000_0008};
    send_frame(8'h01, 1'b1, 0);
    send_frame(8'h02, 1'b1, 0);
    send_frame(8'h03, 1'b1, 0);
    idle(4);
    peek(STAT, d, v);
    n_vec++; if (d !== 32'h0000_0300) begin n_bad++; $display("FAIL b2b_status_3 got %h want 00000300", d); end
    for (int i = 0; i < 3; i++) begin
      do_read(BASE, d, v);
      n_vec++; if (d !== 32'(i + 1)) begin n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", i, d, 32'(i + 1)); end
      peek(STAT, d, v);
      n_vec++; if (d !== exp_st[i]) begin n_bad++; $display("FAIL b2b_status[%0d] got %h want %h", i, d, exp_st[i]); end
    end
  endtask

  task automatic test_overrun;
    logic [31:0] d;
    logic v;
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1, 0);
    idle(4);
    peek(STAT, d, v);
    n_vec++; if (d !== 32'h0000_0405) begin n_bad++; $display("FAIL ovr_status_full got %h want 00000405", d); end
    for (int i = 0; i < 4; i++) begin
      do_read(BASE, d, v);
      n_vec++; if (d !== 32'h10 + 32'(i)) begin n_bad++;
        $display("FAIL ovr_data[%0d] got %h want %h", i, d, 32'h10 + 32'(i)); end
    end
    do_write(BASE, 3'd1, 32'h0000_0055);
    peek(STAT, d, v);
    n_vec++; if (d !== 32'h0000_0009) begin n_bad++; $display("FAIL ovr_status_drained got %h want 00000009", d); end
    do_write(STAT, 3'd1, 32'h0000_0001);
    peek(STAT, d, v);
    n_vec++; if (d !== 32'h0000_0008) begin n_bad++; $display("FAIL ovr_status_cleared got %h want 00000008", d); end
  endtask

  task automatic test_frame_glitch;
    logic [31:0] d;
    logic v;
    send_frame(8'h55, 1'b0, 0);
    idle(20);
    peek(STAT, d, v);
    n_vec++; if (d !== 32'h0000_000A) begin n_bad++; $display("FAIL frame_status got %h want 0000000a", d); end
    do_write(STAT, 3'd2, 32'h0000_0003);
    peek(STAT, d, v);
    n_vec++; if (d !== 32'h0000_000A) begin n_bad++; $display("FAIL frame_set_bits_noop got %h want 0000000a", d); end
    do_write(STAT, 3'd3, 32'h0000_0002);
    peek(STAT, d, v);
    n_vec++; if (d !== 32'h0000_0008) begin n_bad++; $display("FAIL frame_cleared got %h want 00000008", d); end
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    peek(STAT, d, v);
    n_vec++; if (d !== 32'h0000_0008) begin n_bad++; $display("FAIL glitch_status got %h want 00000008", d); end
  endtask

  task automatic test_pop_push;
    logic [31:0] d;
    logic v;
    logic [7:0] exp_b [4];
    exp_b = '{8'h31, 8'h32, 8'h33, 8'h99};
    for (int i = 0; i < 4; i++) send_frame(8'h30 + 8'(i), 1'b1, 0);
    idle(4);
    peek(STAT, d, v);
    n_vec++; if (d !== 32'h0000_0404) begin n_bad++; $display("FAIL pp_status_full got %h want 00000404", d); end
    // Stop bit is sampled at edge 155 of the frame; pop on that same edge.
    pop_seen = 32'hDEAD_BEEF;
    send_frame(8'h99, 1'b1, 155);
    n_vec++; if (pop_seen !== 32'h0000_0030) begin n_bad++; $display("FAIL pp_pop_data got %h want 00000030", pop_seen); end
    idle(4);
    peek(STAT, d, v);
    n_vec++; if (d !== 32'h0000_0404) begin n_bad++; $display("FAIL pp_status_after got %h want 00000404", d); end
    for (int i = 0; i < 4; i++) begin
      do_read(BASE, d, v);
      n_vec++; if (d !== {24'h0, exp_b[i]}) begin n_bad++;
        $display("FAIL pp_data[%0d] got %h want %h", i, d, {24'h0, exp_b[i]}); end
    end
    peek(STAT, d, v);
    n_vec++; if (d !== 32'h0000_0008) begin n_bad++; $display("FAIL pp_status_empty got %h want 00000008", d); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] d;
    logic v;
    send_frame(8'h77, 1'b1, 0);
    idle(4);
    peek(STAT, d, v);
    n_vec++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL rmf_status_pre got %h want 00000100", d); end
    // Partial frame: start, bits 0..2 low, then bit 3 high with reset mid-bit.
    rx = 1'b0;
    idle(64);
    rx = 1'b1;
    idle(8);
    rstn = 1'b0;
    idle(1);
    rstn = 1'b1;
    idle(40);
    peek(STAT, d, v);
    n_vec++; if (d !== 32'h0000_0008) begin n_bad++; $display("FAIL rmf_status_reset got %h want 00000008", d); end
    send_frame(8'h3C, 1'b1, 0);
    idle(4);
    peek(STAT, d, v);
    n_vec++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL rmf_status_post got %h want 00000100", d); end
    do_read(BASE, d, v);
    n_vec++; if (d !== 32'h0000_003C) begin n_bad++; $display("FAIL rmf_data got %h want 0000003c", d); end
    do_read(BASE, d, v);
    n_vec++; if (d !== 32'h8000_0000) begin n_bad++; $display("FAIL rmf_empty got %h want 80000000", d); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overrun;
    test_frame_glitch;
    test_pop_push;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
